// File: rtl/alu_pkg.sv
// ALU command encoding shared by the datapath and its control unit.
package alu;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SHL,
    ALU_SHR
  } AluCmd;

endpackage

// File: rtl/ctrl_pkg.sv
// Control-unit types: instruction opcodes, sequencer states and datapath mux controls.
package ctrl;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } Opcode;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } CtrlState;

  typedef struct packed {
    logic dst_in_sel;  // 1 = immediate, 0 = ALU result
  } CtrlSig;

endpackage

// File: rtl/ctrl_decoder.sv
// Pure combinational opcode decode; gating with the EXEC state is done by the caller.
module ctrl_decoder
  import alu::*;
  import ctrl::*;
(
  input  logic [3:0] opcode,
  output logic       reg_wr_en_raw,
  output AluCmd      alu_cmd,
  output CtrlSig     ctrl_sig,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    reg_wr_en_raw = 1'b0;
    alu_cmd       = ALU_ADD;
    ctrl_sig      = '0;
    is_jmp        = 1'b0;
    is_halt       = 1'b0;
    is_illegal    = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_LDI:  begin reg_wr_en_raw = 1'b1; ctrl_sig.dst_in_sel = 1'b1; end
      OP_ADD:  reg_wr_en_raw = 1'b1;
      OP_SUB:  begin reg_wr_en_raw = 1'b1; alu_cmd = ALU_SUB; end
      OP_AND:  begin reg_wr_en_raw = 1'b1; alu_cmd = ALU_AND; end
      OP_OR:   begin reg_wr_en_raw = 1'b1; alu_cmd = ALU_OR;  end
      OP_XOR:  begin reg_wr_en_raw = 1'b1; alu_cmd = ALU_XOR; end
      OP_SHL:  begin reg_wr_en_raw = 1'b1; alu_cmd = ALU_SHL; end
      OP_SHR:  begin reg_wr_en_raw = 1'b1; alu_cmd = ALU_SHR; end
      OP_JMP:  is_jmp  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;  // A..E behave as NOP
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Fetch/decode sequencer: fetches 16-bit instructions over req/ack and drives
// the datapath controls for one EXEC cycle per instruction.
module ctrl_unit
  import alu::*;
  import ctrl::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic            reg_wr_en,
  output logic [11:0]     operands,
  output AluCmd           alu_cmd,
  output CtrlSig          ctrl_sig,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  CtrlState    state;
  CtrlState    next_state;
  logic [15:0] ir;
  logic        illegal_q;
  logic        reg_wr_en_raw;
  logic        is_jmp;
  logic        is_halt;
  logic        is_illegal;

  ctrl_decoder u_decoder (
    .opcode        (ir[15:12]),
    .reg_wr_en_raw (reg_wr_en_raw),
    .alu_cmd       (alu_cmd),
    .ctrl_sig      (ctrl_sig),
    .is_jmp        (is_jmp),
    .is_halt       (is_halt),
    .is_illegal    (is_illegal)
  );

  assign operands  = ir[11:0];
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (run) next_state = ST_FETCH;
      ST_FETCH: if (imem_ack) next_state = ST_EXEC;
      ST_EXEC:  next_state = is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:  if (run) next_state = ST_FETCH;
      default:  next_state = ST_IDLE;
    endcase
  end

  // IR, pc, sticky illegal flag and the registered fetch request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= '0;
      pc        <= '0;
      illegal_q <= 1'b0;
      imem_req  <= 1'b0;
    end else begin
      imem_req <= (next_state == ST_FETCH);
      if (state == ST_FETCH && imem_ack) ir <= imem_data;
      if (state == ST_EXEC) begin
        pc <= is_jmp ? ir[PC_W-1:0] : pc + PC_W'(1);
        if (is_illegal) illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    reg_wr_en = (state == ST_EXEC) && reg_wr_en_raw;
    halted    = (state == ST_HALT);
    illegal   = illegal_q || ((state == ST_EXEC) && is_illegal);
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed scenarios plus randomized instruction
// streams against an instruction-level reference model.
module tb_ctrl_unit;
  import alu::*;
  import ctrl::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        reg_wr_en;
  logic [11:0] operands;
  AluCmd       alu_cmd;
  CtrlSig      ctrl_sig;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;

  // Narrow-PC instance used only to observe address wrap.
  logic        run4 = 1'b1;
  logic        req4;
  logic [3:0]  addr4;
  logic        ack4;
  logic [15:0] data4 = 16'h2000;
  logic        wr4;
  logic [11:0] opnd4;
  AluCmd       alu4;
  CtrlSig      sig4;
  logic [3:0]  pc4;
  logic        halted4;
  logic        ill4;

  assign ack4 = req4;

  always #5 clk = ~clk;

  ctrl_unit #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .reg_wr_en(reg_wr_en), .operands(operands), .alu_cmd(alu_cmd), .ctrl_sig(ctrl_sig),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  ctrl_unit #(.PC_W(4)) dut4 (
    .clk(clk), .rst(rst), .run(run4),
    .imem_req(req4), .imem_addr(addr4), .imem_ack(ack4), .imem_data(data4),
    .reg_wr_en(wr4), .operands(opnd4), .alu_cmd(alu4), .ctrl_sig(sig4),
    .pc(pc4), .halted(halted4), .illegal(ill4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: architectural pc, sticky illegal, last loaded operand field.
  int          exp_pc   = 0;
  bit          exp_ill  = 1'b0;
  logic [11:0] exp_opnd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_wr(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h8);
  endfunction

  function automatic AluCmd exp_alu(input logic [3:0] op);
    case (op)
      4'h3:    return ALU_SUB;
      4'h4:    return ALU_AND;
      4'h5:    return ALU_OR;
      4'h6:    return ALU_XOR;
      4'h7:    return ALU_SHL;
      4'h8:    return ALU_SHR;
      default: return ALU_ADD;
    endcase
  endfunction

  // One instruction: the request must be up at the next falling edge, ack after
  // 'waits' idle cycles, then the following cycle is EXEC.
  task automatic do_fetch(input logic [15:0] instr, input int waits);
    logic [3:0] op;
    op = instr[15:12];
    @(negedge clk);
    check("req_up", imem_req, 1'b1);
    check("fetch_addr", imem_addr, exp_pc[7:0]);
    check("opnd_hold", operands, exp_opnd);
    check("illegal_flag", illegal, exp_ill);
    check("not_halted", halted, 1'b0);
    run      = 1'($urandom);
    imem_ack = 1'b0;
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      run = 1'($urandom);
      check("wait_req", imem_req, 1'b1);
      check("wait_addr", imem_addr, exp_pc[7:0]);
      check("wait_wr", reg_wr_en, 1'b0);
      check("wait_pc", pc, exp_pc[7:0]);
    end
    imem_ack  = 1'b1;
    imem_data = instr;
    @(negedge clk);
    // Spurious ack with junk data during EXEC must be ignored.
    imem_ack  = 1'($urandom);
    imem_data = 16'($urandom);
    run       = (op == 4'hF) ? 1'b0 : 1'($urandom);
    check("exec_wr", reg_wr_en, exp_wr(op));
    check("exec_opnd", operands, instr[11:0]);
    check("exec_alu", alu_cmd, exp_alu(op));
    check("exec_dst", ctrl_sig.dst_in_sel, (op == 4'h1));
    check("exec_req", imem_req, 1'b0);
    check("exec_pc", pc, exp_pc[7:0]);
    exp_opnd = instr[11:0];
    exp_pc   = (op == 4'h9) ? int'(instr[7:0]) : (exp_pc + 1) % 256;
    if (op >= 4'hA && op <= 4'hE) exp_ill = 1'b1;
  endtask

  // Sit in HALT for n cycles with junk acks, then pulse run for one cycle.
  task automatic halt_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      imem_ack  = 1'($urandom);
      imem_data = 16'($urandom);
      check("halt_noreq", imem_req, 1'b0);
      check("halt_flag", halted, 1'b1);
      check("halt_pc", pc, exp_pc[7:0]);
    end
    imem_ack = 1'b0;
    run      = 1'b1;
  endtask

  initial begin
    logic [15:0] instr;
    bit          found;
    rst       = 1'b1;
    run       = 1'b1;
    imem_ack  = 1'b0;
    imem_data = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 8'h00);
    check("rst_req", imem_req, 1'b0);
    check("rst_wr", reg_wr_en, 1'b0);
    check("rst_opnd", operands, 12'h000);
    check("rst_alu", alu_cmd, ALU_ADD);
    check("rst_dst", ctrl_sig.dst_in_sel, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    rst = 1'b0;

    do_fetch(16'h1305, 0);  // LDI r3,5
    do_fetch(16'h2435, 0);  // ADD r4,r3,r5
    do_fetch(16'hF000, 0);  // HALT at 2
    halt_phase(10);
    do_fetch(16'h3123, 3);  // delayed ack at 3
    do_fetch(16'h9020, 0);  // JMP at 4
    do_fetch(16'hB123, 0);  // illegal at 0x20
    do_fetch(16'h5ABC, 1);

    for (int i = 0; i < 40; i++) begin
      instr = 16'($urandom);
      do_fetch(instr, int'($urandom_range(0, 3)));
      if (instr[15:12] == 4'hF) halt_phase(3);
    end

    do_fetch(16'h90FF, 0);  // jump to last address
    do_fetch(16'h8F12, 0);  // non-jump at 0xFF wraps
    do_fetch(16'h0000, 2);  // fetched from address 0

    // Reset while a request is up and the ack arrives in the same cycle.
    @(negedge clk);
    check("mid_req", imem_req, 1'b1);
    imem_ack  = 1'b1;
    imem_data = 16'h7777;
    rst       = 1'b1;
    #1;
    check("mid_rst_wr", reg_wr_en, 1'b0);
    check("mid_rst_pc", pc, 8'h00);
    check("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_ill", illegal, 1'b0);
    check("mid_rst_opnd", operands, 12'h000);
    @(posedge clk);
    #1;
    check("mid_rst_wr2", reg_wr_en, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    exp_pc   = 0;
    exp_ill  = 1'b0;
    exp_opnd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_noreq", imem_req, 1'b0);
      check("idle_pc", pc, 8'h00);
    end
    run = 1'b1;
    do_fetch(16'h1ABC, 0);

    // PC_W=4: the fetch after address 0xF must be at 0.
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (req4 && addr4 == 4'hF) found = 1'b1;
    end
    check("w4_reach_f", found, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("w4_wrap_req", req4, 1'b1);
    check("w4_wrap_addr", addr4, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
